// File: rtl/sel_split_pkg.sv
// Shared types and limits for the sel_split_n conditional-split block.
package sel_split_pkg;

    localparam int SEL_MAX_N   = 16;
    localparam int SEL_MAX_DLY = 7;

    typedef enum logic [1:0] {
        SEL_ST_IDLE    = 2'd0,
        SEL_ST_WAIT    = 2'd1,
        SEL_ST_RELEASE = 2'd2
    } sel_state_t;

endpackage

// File: rtl/pulse_delay.sv
// Delays a single-cycle pulse by DLY (0..7) cycles; DLY = 0 is a pass-through.
// Only one pulse may be in flight, so a loadable down-counter replaces a shift register.
module pulse_delay
    import sel_split_pkg::*;
#(
    parameter int DLY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic pulse_out
);

    localparam int CW = $clog2(SEL_MAX_DLY + 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (pulse_in) begin
            cnt <= CW'(DLY);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign pulse_out = (DLY == 0) ? pulse_in : (cnt == CW'(1));

endmodule

// File: rtl/sel_split_n.sv
// N-way conditional split: fans one drive pulse out to the masked branches, joins their frees.
// Optional stall watchdog built when SEL_SPLIT_TIMEOUT_EN is defined.
module sel_split_n
    import sel_split_pkg::*;
#(
    parameter int N        = 2,
    parameter int FREE_DLY = 2,
    parameter int TO_W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_drive,
    input  logic [N-1:0] i_valid,
    input  logic [N-1:0] i_freeNext,
    output logic         o_free,
    output logic [N-1:0] o_driveNext,
    output logic         o_busy,
    output logic [N-1:0] o_pending,
    output logic         o_err,
    output logic         o_timeout
);

    sel_state_t   state;
    sel_state_t   state_next;
    logic [N-1:0] pending;
    logic [N-1:0] pending_next;
    logic [N-1:0] free_acc;
    logic [N-1:0] free_bad;
    logic         drive_ok;
    logic         drive_bad;
    logic         done;
    logic         rel_fire;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        drive_ok     = i_drive && (state == SEL_ST_IDLE);
        drive_bad    = i_drive && (state != SEL_ST_IDLE);
        free_acc     = i_freeNext & pending;
        free_bad     = i_freeNext & ~pending;
        pending_next = pending & ~free_acc;
        // The join is complete either on an empty-mask drive or when the last owed free lands.
        done         = (drive_ok && (i_valid == '0)) ||
                       ((state == SEL_ST_WAIT) && (pending_next == '0));
    end

    pulse_delay #(
        .DLY (FREE_DLY)
    ) u_free_dly (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (done),
        .pulse_out (rel_fire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEL_ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEL_ST_IDLE: begin
                if (drive_ok) begin
                    state_next = (i_valid != '0) ? SEL_ST_WAIT : SEL_ST_RELEASE;
                end
            end
            SEL_ST_WAIT: begin
                if (pending_next == '0) begin
                    state_next = SEL_ST_RELEASE;
                end
            end
            SEL_ST_RELEASE: state_next = SEL_ST_RELEASE;
            default:        state_next = SEL_ST_IDLE;
        endcase
        // Returning to IDLE on the o_free edge lets a drive in the o_free cycle be accepted.
        if (rel_fire) begin
            state_next = SEL_ST_IDLE;
        end
    end

    always_comb begin
        o_busy    = (state != SEL_ST_IDLE);
        o_pending = pending;
    end

    // NOTE: no memories here, so every register, including pending, is cleared by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            o_driveNext <= '0;
            o_free      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            if (drive_ok) begin
                pending <= i_valid;
            end else if (state == SEL_ST_WAIT) begin
                pending <= pending_next;
            end
            o_driveNext <= drive_ok ? i_valid : '0;
            o_free      <= rel_fire;
            o_err       <= o_err | drive_bad | (|free_bad);
        end
    end

`ifdef SEL_SPLIT_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_flag;

    // Counter saturates at all-ones; the flag rises in the same cycle the count gets there.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (drive_ok) begin
                to_cnt <= '0;
            end else if (state == SEL_ST_WAIT) begin
                if (|free_acc) begin
                    to_cnt <= '0;
                end else if (to_cnt != '1) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
            if ((state == SEL_ST_WAIT) && !(|free_acc) && (to_cnt == ~TO_W'(1))) begin
                to_flag <= 1'b1;
            end
        end
    end

    assign o_timeout = to_flag;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sel_split_n.sv
// Directed bench for sel_split_n: one instance with FREE_DLY=2, one with FREE_DLY=0.
module tb_sel_split_n;

    logic       clk = 1'b0;
    logic       rst;

    logic       drv_a, free_a, busy_a, err_a, to_a;
    logic [3:0] val_a, frn_a, dn_a, pend_a;
    logic       drv_b, free_b, busy_b, err_b, to_b;
    logic [3:0] val_b, frn_b, dn_b, pend_b;
    logic       exp_to;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sel_split_n #(.N(4), .FREE_DLY(2), .TO_W(4)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (drv_a),
        .i_valid     (val_a),
        .i_freeNext  (frn_a),
        .o_free      (free_a),
        .o_driveNext (dn_a),
        .o_busy      (busy_a),
        .o_pending   (pend_a),
        .o_err       (err_a),
        .o_timeout   (to_a)
    );

    sel_split_n #(.N(4), .FREE_DLY(0), .TO_W(4)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (drv_b),
        .i_valid     (val_b),
        .i_freeNext  (frn_b),
        .o_free      (free_b),
        .o_driveNext (dn_b),
        .o_busy      (busy_b),
        .o_pending   (pend_b),
        .o_err       (err_b),
        .o_timeout   (to_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance into the next cycle; single-cycle pulses default low.
    task automatic tick();
        @(posedge clk);
        #1;
        drv_a = 1'b0;
        frn_a = '0;
        drv_b = 1'b0;
        frn_b = '0;
    endtask

    initial begin
`ifdef SEL_SPLIT_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        rst   = 1'b1;
        val_a = '0;
        val_b = '0;
        drv_a = 1'b0;
        frn_a = '0;
        drv_b = 1'b0;
        frn_b = '0;
        tick();
        tick();
        check("rst_dn",   dn_a,   4'b0000);
        check("rst_pend", pend_a, 4'b0000);
        check("rst_busy", busy_a, 1'b0);
        check("rst_free", free_a, 1'b0);
        check("rst_err",  err_a,  1'b0);
        check("rst_to",   to_a,   1'b0);
        rst = 1'b0;
        tick();

        // Mask 0101, frees on branch 0 then branch 2, FREE_DLY=2.
        drv_a = 1'b1; val_a = 4'b0101;
        tick();
        check("t1_dn",   dn_a,   4'b0101);
        check("t1_pend", pend_a, 4'b0101);
        check("t1_busy", busy_a, 1'b1);
        tick();
        check("t1_dn_off", dn_a, 4'b0000);
        tick();
        frn_a = 4'b0001;
        tick();
        check("t1_pend2", pend_a, 4'b0100);
        tick();
        frn_a = 4'b0100;
        tick();
        check("t1_pend0", pend_a, 4'b0000);
        check("t1_busy_rel", busy_a, 1'b1);
        check("t1_free_u1", free_a, 1'b0);
        tick();
        check("t1_free_u2", free_a, 1'b0);
        tick();
        check("t1_free", free_a, 1'b1);
        check("t1_idle", busy_a, 1'b0);
        check("t1_err",  err_a,  1'b0);
        tick();
        check("t1_free_off", free_a, 1'b0);

        // Empty mask: no branch driven, free after 1+FREE_DLY cycles.
        drv_a = 1'b1; val_a = 4'b0000;
        tick();
        check("t3_dn",   dn_a,   4'b0000);
        check("t3_busy", busy_a, 1'b1);
        tick();
        check("t3_free_early", free_a, 1'b0);
        tick();
        check("t3_free", free_a, 1'b1);
        check("t3_idle", busy_a, 1'b0);
        check("t3_err",  err_a,  1'b0);

        // Drive while busy plus a free on an unselected branch.
        drv_a = 1'b1; val_a = 4'b0001;
        tick();
        check("t4_pend", pend_a, 4'b0001);
        tick();
        drv_a = 1'b1; val_a = 4'b1111; frn_a = 4'b0010;
        tick();
        check("t4_err",     err_a,  1'b1);
        check("t4_pend2",   pend_a, 4'b0001);
        check("t4_no_dn",   dn_a,   4'b0000);
        frn_a = 4'b0001;
        tick();
        check("t4_busy", busy_a, 1'b1);
        tick();
        tick();
        check("t4_free", free_a, 1'b1);
        check("t4_idle", busy_a, 1'b0);
        check("t4_err_sticky", err_a, 1'b1);

        // Reset mid-transaction, then a late free.
        drv_a = 1'b1; val_a = 4'b0110;
        tick();
        check("t5_pend", pend_a, 4'b0110);
        tick();
        rst = 1'b1;
        tick();
        check("t5_dn",   dn_a,   4'b0000);
        check("t5_pend0", pend_a, 4'b0000);
        check("t5_busy", busy_a, 1'b0);
        check("t5_err",  err_a,  1'b0);
        check("t5_free", free_a, 1'b0);
        rst = 1'b0;
        tick();
        frn_a = 4'b0010;
        tick();
        check("t5_late_err", err_a,  1'b1);
        check("t5_idle",     busy_a, 1'b0);

        // Watchdog: one branch never frees.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        drv_a = 1'b1; val_a = 4'b0001;
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("t6_to_pre", to_a,   1'b0);
        tick();
        check("t6_to",     to_a,   exp_to);
        check("t6_busy",   busy_a, 1'b1);
        tick();
        check("t6_to_hold", to_a,  exp_to);

        // FREE_DLY=0 instance: all frees together, back-to-back drive, early ack.
        drv_b = 1'b1; val_b = 4'b1111;
        tick();
        check("t2_dn", dn_b, 4'b1111);
        frn_b = 4'b1111;
        tick();
        check("t2_free", free_b, 1'b1);
        check("t2_idle", busy_b, 1'b0);
        drv_b = 1'b1; val_b = 4'b0011;
        tick();
        check("t2_dn2",   dn_b,   4'b0011);
        check("t2_busy2", busy_b, 1'b1);
        check("t2_free_off", free_b, 1'b0);
        frn_b = 4'b0011;
        tick();
        check("t2_free2", free_b, 1'b1);
        check("t2_err",   err_b,  1'b0);
        drv_b = 1'b1; val_b = 4'b0001; frn_b = 4'b0001;
        tick();
        check("ea_err",  err_b,  1'b1);
        check("ea_pend", pend_b, 4'b0001);
        frn_b = 4'b0001;
        tick();
        check("ea_free", free_b, 1'b1);
        check("b_to",    to_b,   1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
